hazard_scoreboard: RTL and testbench

Register-dependency scoreboard that sequences the decode stage. It tracks every in-flight destination register between issue and write-back with per-register pending counters. It raises `STALL` to hold decode while a source operand is still pending, and produces the issue strobe that advances decode into execute. It sits beside the decode stage: it reads the decode-stage instruction and valid bit, and it receives retirement information from write-back.

---
 rtl/hazard_scoreboard_if.sv | 19 +
 rtl/hazard_scoreboard.sv | 76 +++++++
 tb/tb_hazard_scoreboard.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode, write-back and status bundle for hazard_scoreboard; stall_cycles exists only with HAZARD_SCB_PERF_EN
interface hazard_scoreboard_if;
  logic de_v;
  logic [31:0] de_ir;
  logic wb_v;
  logic [4:0] wb_rd;
  logic flush;
  logic stall;
  logic issue;
  logic busy;
`ifdef HAZARD_SCB_PERF_EN
  logic [31:0] stall_cycles;
  modport master(output de_v, de_ir, wb_v, wb_rd, flush, input stall, issue, busy, stall_cycles);
  modport slave(input de_v, de_ir, wb_v, wb_rd, flush, output stall, issue, busy, stall_cycles);
`else
  modport master(output de_v, de_ir, wb_v, wb_rd, flush, input stall, issue, busy);
  modport slave(input de_v, de_ir, wb_v, wb_rd, flush, output stall, issue, busy);
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters that stall decode on RAW and counter-overflow hazards; HAZARD_SCB_PERF_EN adds the stall_cycles counter
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [31:0] pend;
  logic [31:0] full;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [6:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic wr;
  logic use1;
  logic use2;
  logic any_nxt;
  logic unused_ir;
  assign op = bus.de_ir[6:0];
  assign rd = bus.de_ir[11:7];
  assign rs1 = bus.de_ir[19:15];
  assign rs2 = bus.de_ir[24:20];
  assign unused_ir = ^{bus.de_ir[31:25], bus.de_ir[14:12]};
  // opcode class decode; x0 is never a real source or destination
  always_comb begin
    wr = rd != 5'd0 && (op inside {7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
    use1 = rs1 != 5'd0 && (op inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011, 7'b1100111});
    use2 = rs2 != 5'd0 && (op inside {7'b0100011, 7'b0110011, 7'b1100011});
  end
  // per-register pending and saturated flags, widened to the 5-bit register space
  always_comb begin
    pend = '0;
    full = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pend[r] = |cnt[r];
      full[r] = &cnt[r];
    end
  end
  assign bus.stall = bus.de_v & ((use1 & pend[rs1]) | (use2 & pend[rs2]) | (wr & full[rd]));
  assign bus.issue = bus.de_v & ~bus.stall & ~bus.flush;
  // next counter values: flush clears, issue/retire on one register cancel, retire saturates at zero
  always_comb begin
    inc = '0;
    dec = '0;
    any_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = bus.issue & wr & (rd == 5'(r));
      dec[r] = bus.wb_v & (bus.wb_rd == 5'(r));
      cnt_nxt[r] = (bus.flush || r == 0) ? '0 :
                   (inc[r] && !dec[r]) ? cnt[r] + 1'b1 :
                   (dec[r] && !inc[r] && cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
      any_nxt = any_nxt | (|cnt_nxt[r]);
    end
  end
  // counter bank and busy flag, busy tracks the post-edge counter state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '{default: '0};
      bus.busy <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      bus.busy <= any_nxt;
    end
`ifdef HAZARD_SCB_PERF_EN
  // free-running stall-cycle count, survives flush, wraps at 2^32
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.stall_cycles <= '0;
    else if (bus.stall && !bus.flush) bus.stall_cycles <= bus.stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic checked against an array-of-counts reference model
module tb_hazard_scoreboard;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int mcnt [32];
  int mperf = 0;
  hazard_scoreboard_if bus();
  hazard_scoreboard dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(logic [6:0] op, int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  function automatic bit m_wr(logic [31:0] ir);
    return ir[11:7] != 0 && (ir[6:0] inside {7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
  endfunction

  function automatic bit m_u1(logic [31:0] ir);
    return ir[19:15] != 0 && (ir[6:0] inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011, 7'b1100111});
  endfunction

  function automatic bit m_u2(logic [31:0] ir);
    return ir[24:20] != 0 && (ir[6:0] inside {7'b0100011, 7'b0110011, 7'b1100011});
  endfunction

  function automatic bit m_stall(bit dv, logic [31:0] ir);
    return dv && ((m_u1(ir) && mcnt[ir[19:15]] != 0) || (m_u2(ir) && mcnt[ir[24:20]] != 0) || (m_wr(ir) && mcnt[ir[11:7]] == MAXC));
  endfunction

  function automatic bit m_busy();
    foreach (mcnt[i]) if (mcnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(bit dv, logic [31:0] ir, bit wv, int wrd, bit fl);
    @(negedge clk);
    bus.de_v = dv;
    bus.de_ir = ir;
    bus.wb_v = wv;
    bus.wb_rd = 5'(wrd);
    bus.flush = fl;
    #1;
  endtask

  task automatic tick();
    bit ms, iss, wv, fl;
    logic [31:0] ir;
    int rd, wrd;
    ir = bus.de_ir;
    wv = bus.wb_v;
    fl = bus.flush;
    ms = m_stall(bus.de_v, ir);
    iss = bus.de_v && !ms && !fl;
    rd = int'(ir[11:7]);
    wrd = int'(bus.wb_rd);
    @(posedge clk);
    #1;
    if (fl) begin
      foreach (mcnt[i]) mcnt[i] = 0;
    end else begin
      if (iss && m_wr(ir)) mcnt[rd]++;
      if (wv) begin
        if (iss && m_wr(ir) && rd == wrd) mcnt[rd]--;
        else if (mcnt[wrd] > 0) mcnt[wrd]--;
      end
    end
    if (ms && !fl) mperf++;
  endtask

  task automatic test_reset();
    int nz;
    foreach (mcnt[i]) mcnt[i] = 0;
    mperf = 0;
    rst = 1'b1;
    bus.de_v = 1'b1;
    bus.de_ir = ins(OP_ADD, 1, 2, 3);
    bus.wb_v = 1'b0;
    bus.wb_rd = 5'd0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL reset_stall_issue: got %b want 01", {bus.stall, bus.issue}); end
    nz = 0;
    for (int r = 0; r < 32; r++) if (int'(dut.cnt[r]) != 0) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL reset_cnt: got %0d nonzero counters want 0", nz); end
`ifdef HAZARD_SCB_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_perf: got %0d want 0", bus.stall_cycles); end
`endif
    @(negedge clk);
    bus.de_v = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_independent();
    drive(1, ins(OP_ADD, 1, 2, 3), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL indep_first: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    drive(1, ins(OP_ADD, 4, 5, 6), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL indep_second: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL indep_busy: got %b want 1", bus.busy); end
    total++;
    if (int'(dut.cnt[1]) != 1 || int'(dut.cnt[4]) != 1) begin bad++; $display("FAIL indep_cnt: got cnt1=%0d cnt4=%0d want 1 1", dut.cnt[1], dut.cnt[4]); end
    drive(0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 4, 0);
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL indep_drain: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_raw();
    int p0;
    drive(1, ins(OP_ADD, 5, 1, 2), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL raw_producer: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    p0 = mperf;
    for (int c = 1; c <= 3; c++) begin
      drive(1, ins(OP_ADD, 6, 5, 5), c == 3, 5, 0);
      total++;
      if ({bus.stall, bus.issue} !== 2'b10) begin bad++; $display("FAIL raw_stall c%0d: got %b want 10", c, {bus.stall, bus.issue}); end
      tick();
    end
    drive(1, ins(OP_ADD, 6, 5, 5), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL raw_release: got %b want 01", {bus.stall, bus.issue}); end
    tick();
`ifdef HAZARD_SCB_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'(p0 + 3)) begin bad++; $display("FAIL raw_perf: got %0d want %0d", bus.stall_cycles, p0 + 3); end
`endif
    drive(0, 0, 1, 6, 0);
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL raw_drain: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_same_cycle();
    drive(1, ins(OP_ADDI, 7, 0, 0), 0, 0, 0);
    tick();
    drive(1, ins(OP_ADDI, 7, 0, 0), 1, 7, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL same_issue: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    total++;
    if (int'(dut.cnt[7]) != 1) begin bad++; $display("FAIL same_cnt7: got %0d want 1", dut.cnt[7]); end
    drive(0, 0, 1, 7, 0);
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL same_drain: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive(1, ins(OP_ADDI, 9, 0, 0), 0, 0, 0);
      total++;
      if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL ovf_fill%0d: got %b want 01", i, {bus.stall, bus.issue}); end
      tick();
    end
    total++;
    if (int'(dut.cnt[9]) != 3) begin bad++; $display("FAIL ovf_cnt9: got %0d want 3", dut.cnt[9]); end
    for (int i = 0; i < 3; i++) begin
      drive(1, ins(OP_ADDI, 9, 0, 0), i == 2, 9, 0);
      total++;
      if ({bus.stall, bus.issue} !== 2'b10) begin bad++; $display("FAIL ovf_hold%0d: got %b want 10", i, {bus.stall, bus.issue}); end
      tick();
    end
    drive(1, ins(OP_ADDI, 9, 0, 0), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL ovf_release: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 9, 0);
      tick();
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL ovf_drain: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_x0_store();
    int nz;
    for (int i = 0; i < 10; i++) begin
      drive(1, ins(OP_ADDI, 0, 0, 0) | 32'h0010_0000, 0, 0, 0);
      total++;
      if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL x0_issue%0d: got %b want 01", i, {bus.stall, bus.issue}); end
      tick();
    end
    nz = 0;
    for (int r = 0; r < 32; r++) if (int'(dut.cnt[r]) != 0) nz++;
    total++;
    if (nz != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL x0_cnt: got %0d nonzero busy=%b want 0 0", nz, bus.busy); end
    drive(1, ins(OP_ADDI, 8, 0, 0), 0, 0, 0);
    tick();
    drive(1, ins(OP_SW, 0, 8, 8), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b10) begin bad++; $display("FAIL sw_stall: got %b want 10", {bus.stall, bus.issue}); end
    tick();
    drive(1, ins(OP_SW, 0, 8, 8), 1, 8, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b10) begin bad++; $display("FAIL sw_retire_cycle: got %b want 10", {bus.stall, bus.issue}); end
    tick();
    drive(1, ins(OP_SW, 0, 8, 8), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL sw_release: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL sw_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_flush();
    int nz, p0;
    drive(1, ins(OP_ADDI, 3, 0, 0), 0, 0, 0);
    tick();
    drive(1, ins(OP_ADDI, 3, 0, 0), 0, 0, 0);
    tick();
    drive(1, ins(OP_ADDI, 4, 0, 0), 0, 0, 0);
    tick();
    total++;
    if (int'(dut.cnt[3]) != 2 || int'(dut.cnt[4]) != 1) begin bad++; $display("FAIL flush_setup: got cnt3=%0d cnt4=%0d want 2 1", dut.cnt[3], dut.cnt[4]); end
    p0 = mperf;
    drive(1, ins(OP_ADD, 5, 3, 4), 0, 0, 1);
    total++;
    if ({bus.stall, bus.issue} !== 2'b10) begin bad++; $display("FAIL flush_cycle: got %b want 10", {bus.stall, bus.issue}); end
    tick();
    nz = 0;
    for (int r = 0; r < 32; r++) if (int'(dut.cnt[r]) != 0) nz++;
    total++;
    if (nz != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL flush_clear: got %0d nonzero busy=%b want 0 0", nz, bus.busy); end
`ifdef HAZARD_SCB_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'(p0)) begin bad++; $display("FAIL flush_perf: got %0d want %0d", bus.stall_cycles, p0); end
`endif
    drive(1, ins(OP_ADD, 5, 3, 4), 0, 0, 0);
    total++;
    if ({bus.stall, bus.issue} !== 2'b01) begin bad++; $display("FAIL flush_dependent: got %b want 01", {bus.stall, bus.issue}); end
    tick();
    drive(0, 0, 1, 5, 0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, ins(OP_ADDI, 2, 0, 0), 0, 0, 0);
    tick();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL areset_pre: got busy=%b want 1", bus.busy); end
    @(negedge clk);
    bus.de_v = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || int'(dut.cnt[2]) != 0) begin bad++; $display("FAIL areset_clear: got busy=%b cnt2=%0d want 0 0", bus.busy, dut.cnt[2]); end
    foreach (mcnt[i]) mcnt[i] = 0;
    mperf = 0;
`ifdef HAZARD_SCB_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL areset_perf: got %0d want 0", bus.stall_cycles); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{OP_LD, OP_SW, OP_ADDI, OP_ADD, 7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
    int nz;
    for (int c = 0; c < 400; c++) begin
      int cand[$];
      logic [31:0] ir;
      bit dv, wv, fl, ms;
      int wrd;
      cand.delete();
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) cand.push_back(r);
      ir = $urandom;
      ir[6:0] = ops[$urandom_range(0, 8)];
      ir[11:7] = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
      dv = $urandom_range(0, 3) != 0;
      wv = cand.size() > 0 && $urandom_range(0, 2) == 0;
      wrd = wv ? cand[$urandom_range(0, cand.size() - 1)] : int'($urandom_range(0, 31));
      fl = $urandom_range(0, 39) == 0;
      drive(dv, ir, wv, wrd, fl);
      ms = m_stall(dv, ir);
      total++;
      if ({bus.stall, bus.issue} !== {ms, dv && !ms && !fl}) begin bad++; $display("FAIL rand_stall_issue c%0d: got %b want %b", c, {bus.stall, bus.issue}, {ms, dv && !ms && !fl}); end
      tick();
      total++;
      if (bus.busy !== m_busy()) begin bad++; $display("FAIL rand_busy c%0d: got %b want %b", c, bus.busy, m_busy()); end
    end
    nz = 0;
    for (int r = 0; r < 32; r++) if (int'(dut.cnt[r]) != mcnt[r]) nz++;
    total++;
    if (nz != 0) begin bad++; $display("FAIL rand_cnt: got %0d counters differing from model want 0", nz); end
`ifdef HAZARD_SCB_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'(mperf)) begin bad++; $display("FAIL rand_perf: got %0d want %0d", bus.stall_cycles, mperf); end
`endif
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_same_cycle();
    test_overflow();
    test_x0_store();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
